// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 types, constants, GF(2^8) helpers and reference vectors
package aes_pkg;

  localparam int AES_NR      = 10;
  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  typedef struct packed {
    logic [AES_BLOCK_W-1:0] key;
    logic [AES_BLOCK_W-1:0] pt;
    logic [AES_BLOCK_W-1:0] ct;
  } aes_vec_t;

  // Forward S-box, byte 0x00 in the top eight bits, byte 0xff in the bottom eight.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bit offset (255-b)*8, and 255-b is simply ~b for a byte.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  // Multiply by x in GF(2^8), reducing by 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column: circulant matrix {02,03,01,01}.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // FIPS-197 known-answer vectors: 0 = Appendix B, 1 = Appendix C.1.
  function automatic aes_vec_t fips_vec(input int idx);
    aes_vec_t v;
    if (idx == 0) begin
      v.key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      v.pt  = 128'h3243f6a8885a308d313198a2e0370734;
      v.ct  = 128'h3925841d02dc09fbdc118597196a0b32;
    end else begin
      v.key = 128'h000102030405060708090a0b0c0d0e0f;
      v.pt  = 128'h00112233445566778899aabbccddeeff;
      v.ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    end
    return v;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// rtl/aes_round_ctrl_if.sv - block in/out handshake and debug bundle for the AES controller
interface aes_round_ctrl_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_BLOCK_W-1:0] in_text;
  logic [AES_BLOCK_W-1:0] in_key;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_BLOCK_W-1:0] out_text;
  logic                   busy;
  logic [3:0]             round;

  // Controller side.
  modport slave (
    input  in_valid, in_text, in_key, out_ready,
    output in_ready, out_valid, out_text, busy, round
  );

  // Framer / environment side.
  modport master (
    output in_valid, in_text, in_key, out_ready,
    input  in_ready, out_valid, out_text, busy, round
  );
endinterface

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - one AES-128 key-expansion step (next round key from current key and rcon)
module aes_key_step
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] key,
  input  logic [7:0]             rcon,
  output logic [AES_BLOCK_W-1:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w, mix_w;
  logic [31:0] n0, n1, n2, n3;

  // Word 0 is bytes 0-3, i.e. the top 32 bits.
  assign {w0, w1, w2, w3} = key;

  // RotWord, SubWord and Rcon all act on word 3 only.
  assign rot_w = {w3[23:0], w3[31:24]};
  assign sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                  sbox(rot_w[15:8]),  sbox(rot_w[7:0])};
  assign mix_w = sub_w ^ {rcon, 24'h000000};

  // Each new word chains off the previous new word.
  assign n0 = w0 ^ mix_w;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES-128 encryptor, one round per clock, on-the-fly key expansion
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input logic             clk,
  input logic             rst,
  aes_round_ctrl_if.slave bus
);

  if (NUM_ROUNDS != AES_NR) begin : g_bad_rounds
    $error("aes_round_ctrl: NUM_ROUNDS must be 10 (AES-128 only)");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  aes_state_e             fsm_q, fsm_d;
  logic [AES_BLOCK_W-1:0] state_q, state_d;
  logic [AES_BLOCK_W-1:0] key_q, key_d;
  logic [AES_BLOCK_W-1:0] out_text_q, out_text_d;
  logic [7:0]             rcon_q, rcon_d;
  logic [3:0]             round_q, round_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;

  logic [AES_BLOCK_W-1:0] sb_out, sr_out, mc_out, next_key, round_out;

  // SubBytes: sixteen S-box lookups on the state register.
  for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
    assign sb_out[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
  end

  // ShiftRows: byte (row r, col c) takes byte (row r, col (c+r) mod 4).
  for (genvar c = 0; c < 4; c++) begin : g_shift_col
    for (genvar r = 0; r < 4; r++) begin : g_shift_row
      assign sr_out[127-8*(r+4*c) -: 8] = sb_out[127-8*(r+4*((c+r)%4)) -: 8];
    end
  end

  // MixColumns on each 32-bit column.
  for (genvar c = 0; c < 4; c++) begin : g_mix_col
    assign mc_out[127-32*c -: 32] = mix_column(sr_out[127-32*c -: 32]);
  end

  aes_key_step u_key_step (
    .key      (key_q),
    .rcon     (rcon_q),
    .next_key (next_key)
  );

  // Final round drops MixColumns; every round ends with AddRoundKey.
  assign round_out = ((round_q == LAST_ROUND) ? sr_out : mc_out) ^ next_key;

  // Next-state and next-output decode for the IDLE/ROUND/DONE sequencer.
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    key_d       = key_q;
    out_text_d  = out_text_q;
    rcon_d      = rcon_q;
    round_d     = round_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (fsm_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d    = bus.in_text ^ bus.in_key;
          key_d      = bus.in_key;
          round_d    = 4'd1;
          rcon_d     = 8'h01;
          fsm_d      = ROUND;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      ROUND: begin
        if (round_q == 4'd0 || round_q > LAST_ROUND) begin
          // Unreachable round count: drop the block and recover.
          fsm_d      = IDLE;
          round_d    = 4'd0;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          state_d = round_out;
          key_d   = next_key;
          rcon_d  = xtime(rcon_q);
          if (round_q == LAST_ROUND) begin
            // Counter parks at the last round while the result waits.
            fsm_d       = DONE;
            out_valid_d = 1'b1;
            out_text_d  = round_out;
          end else begin
            round_d = round_q + 4'd1;
          end
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          fsm_d       = IDLE;
          out_valid_d = 1'b0;
          round_d     = 4'd0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end

      default: begin
        fsm_d       = IDLE;
        round_d     = 4'd0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // All controller state and registered outputs; reset aborts any block in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      key_q       <= '0;
      out_text_q  <= '0;
      rcon_q      <= 8'h01;
      round_q     <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      key_q       <= key_d;
      out_text_q  <= out_text_d;
      rcon_q      <= rcon_d;
      round_q     <= round_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_text  = out_text_q;
  assign bus.busy      = busy_q;
  assign bus.round     = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - self-checking bench for aes_round_ctrl
module tb_aes_round_ctrl;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  logic [7:0] sb_ref [256];
  vec_t       tbl [6];
  vec_t       bb [4];

  aes_round_ctrl_if bus ();

  aes_round_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box derived from first principles: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv, s, r;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sb_ref[x] = s ^ 8'h63;
    end
  endtask

  // Textbook AES-128 on a byte array with the full key schedule expanded up front.
  function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   w [44][4];
    logic [7:0]   tmp [4];
    logic [7:0]   rc, x, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w[i][j] = key[127-8*(4*i+j) -: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
      if (i % 4 == 0) begin
        x      = tmp[0];
        tmp[0] = sb_ref[tmp[1]] ^ rc;
        tmp[1] = sb_ref[tmp[2]];
        tmp[2] = sb_ref[tmp[3]];
        tmp[3] = sb_ref[x];
        rc     = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i/4][i%4];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb_ref[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[row+4*c] = s[row+4*((c+row)%4)];
      for (int i = 0; i < 16; i++) s[i] = t[i];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][i%4];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Present a block and return just after its accept edge.
  task automatic accept(input logic [127:0] k, input logic [127:0] p, input bit keep_valid,
                        output int hs_cyc);
    int n;
    bus.in_valid = 1'b1;
    bus.in_text  = p;
    bus.in_key   = k;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) check("accept_timeout_in_ready", {127'd0, bus.in_ready}, 128'd1);
    @(posedge clk); #1;
    hs_cyc = cyc;
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  // Wait for out_valid, checking the round index and scrambling the inputs every cycle.
  task automatic await_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      if (lat < 10) check("round_index", {124'd0, bus.round}, 128'(lat + 1));
      if (lat == 8) check("rcon_at_round9", {120'd0, dut.rcon_q}, 128'h1b);
      @(posedge clk); #1;
      lat++;
      bus.in_text = rnd128();
      bus.in_key  = rnd128();
    end
  endtask

  initial begin
    int lat, hs, prev_hs, n;

    build_sbox();

    tbl[0] = '{KEY_B, PT_B, CT_B};
    tbl[1] = '{KEY_C, PT_C, CT_C};
    for (int i = 2; i < 6; i++) begin
      tbl[i].key = rnd128();
      tbl[i].pt  = rnd128();
      tbl[i].ct  = ref_aes(tbl[i].pt, tbl[i].key);
    end
    for (int i = 0; i < 4; i++) begin
      bb[i].key = rnd128();
      bb[i].pt  = rnd128();
      bb[i].ct  = ref_aes(bb[i].pt, bb[i].key);
    end

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_text   = '0;
    bus.in_key    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",  {127'd0, bus.in_ready},  128'd1);
    check("reset_out_valid", {127'd0, bus.out_valid}, 128'd0);
    check("reset_busy",      {127'd0, bus.busy},      128'd0);
    check("reset_round",     {124'd0, bus.round},     128'd0);
    check("reset_out_text",  bus.out_text,            128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-answer and random vectors, out_ready held high throughout.
    for (int i = 0; i < 6; i++) begin
      accept(tbl[i].key, tbl[i].pt, 1'b0, hs);
      check("busy_after_accept", {127'd0, bus.busy}, 128'd1);
      await_done(lat);
      check("latency", 128'(lat), 128'd10);
      check("ciphertext", bus.out_text, tbl[i].ct);
      @(posedge clk); #1;
    end

    // Back-pressure: result held 20 cycles, a new block offered meanwhile is ignored.
    bus.out_ready = 1'b0;
    accept(KEY_B, PT_B, 1'b0, hs);
    await_done(lat);
    check("bp_latency", 128'(lat), 128'd10);
    for (int k = 0; k < 20; k++) begin
      if (k == 5) begin
        bus.in_valid = 1'b1;
        bus.in_text  = PT_C;
        bus.in_key   = KEY_C;
      end
      if (k == 7) bus.in_valid = 1'b0;
      @(posedge clk); #1;
      check("bp_out_valid", {127'd0, bus.out_valid}, 128'd1);
      check("bp_out_text",  bus.out_text,            CT_B);
      check("bp_in_ready",  {127'd0, bus.in_ready},  128'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", {127'd0, bus.out_valid}, 128'd0);
    check("bp_release_in_ready",  {127'd0, bus.in_ready},  128'd1);
    check("bp_release_busy",      {127'd0, bus.busy},      128'd0);
    accept(KEY_C, PT_C, 1'b0, hs);
    await_done(lat);
    check("bp_second_ciphertext", bus.out_text, CT_C);
    @(posedge clk); #1;

    // Reset at round 5 aborts immediately; a rerun carries no residue.
    accept(KEY_B, PT_B, 1'b0, hs);
    n = 0;
    while (bus.round != 4'd5 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reached_round5", {124'd0, bus.round}, 128'd5);
    rst = 1'b1;
    #1;
    check("abort_out_valid", {127'd0, bus.out_valid}, 128'd0);
    check("abort_busy",      {127'd0, bus.busy},      128'd0);
    check("abort_in_ready",  {127'd0, bus.in_ready},  128'd1);
    check("abort_round",     {124'd0, bus.round},     128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_no_output", {127'd0, bus.out_valid}, 128'd0);
    accept(KEY_B, PT_B, 1'b0, hs);
    await_done(lat);
    check("abort_rerun_latency", 128'(lat), 128'd10);
    check("abort_rerun_ciphertext", bus.out_text, CT_B);
    @(posedge clk); #1;

    // Back-to-back: in_valid and out_ready both held high.
    prev_hs = 0;
    for (int i = 0; i < 4; i++) begin
      accept(bb[i].key, bb[i].pt, 1'b1, hs);
      if (i > 0) check("b2b_spacing", 128'(hs - prev_hs), 128'd12);
      prev_hs = hs;
      await_done(lat);
      check("b2b_ciphertext", bus.out_text, bb[i].ct);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_idle", {127'd0, bus.busy}, 128'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Iterative AES-128 encryption controller that sequences the round datapath, one round per clock: sub_bytes -> shift_rows -> mix_columns -> add_round_key. It sits between the UART receive framer, which delivers a 128-bit plaintext and key, and the UART transmit framer, which consumes the 128-bit ciphertext. It owns the state register, the round-key register, the round counter and the Rcon sequence, and expands the key on the fly.

Parameters:
NUM_ROUNDS, 10, number of cipher rounds; only 10 (AES-128) is legal; any other value is an elaboration error.

Ports:
clk  input  1  system clock; all registers rise-edge triggered
rst  input  1  asynchronous, active-high reset
in_valid  input  1  plaintext/key pair valid
in_ready  output  1  controller can accept a block
in_text  input  128  plaintext; byte 0 = [127:120]; column-major (bytes 0-3 = column 0)
in_key  input  128  cipher key; same byte order
out_valid  output  1  ciphertext valid; held until accepted
out_ready  input  1  downstream accepts ciphertext
out_text  output  128  ciphertext; same byte order
busy  output  1  high in any state other than IDLE
round  output  4  current round index, for debug

Behaviour:
- Reset values (asynchronous, immediate): state=IDLE, in_ready=1, out_valid=0, busy=0, round=0, out_text=0, state/key registers=0, rcon=8'h01.
- The FSM has three states: IDLE, ROUND and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: state_reg <= in_text ^ in_key (initial AddRoundKey); key_reg <= in_key; round <= 1; rcon <= 8'h01; go to ROUND.
- ROUND, one cycle per round:
  - next_key = key_step(key_reg, rcon).
  - If round < NUM_ROUNDS: state_reg <= mix_columns(shift_rows(sub_bytes(state_reg))) ^ next_key.
  - If round == NUM_ROUNDS: MixColumns is skipped; state_reg <= shift_rows(sub_bytes(state_reg)) ^ next_key.
  - Every round cycle: key_reg <= next_key; rcon <= xtime(rcon); round <= round+1.
  - After the round-10 edge: go to DONE, out_valid <= 1, out_text <= result.
- DONE:
  - out_valid=1; out_text is stable.
  - On out_ready: out_valid <= 0, round <= 0, go to IDLE.
  - in_ready is 0 in DONE, so there is no same-cycle accept. The next block is accepted no earlier than the cycle after the out handshake.
- Latency: out_valid rises exactly 10 clock edges after the in handshake edge. Throughput is one block per 12 cycles minimum.
- in_ready=0 in ROUND and DONE. in_valid in those states is ignored, and inputs are not sampled.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36. xtime wraps with polynomial 0x11b; 80 -> 1b is the required wrap.
- The round counter is 4 bits and never exceeds 10. Counter values 0 and 11-15 are unreachable; if an illegal state is ever decoded, the FSM returns to IDLE.
- Reset asserted mid-operation: immediate abort. The partial ciphertext is discarded and never presented; out_valid=0 in the same cycle.
- out_ready held high with no result pending has no effect.
- Inputs are captured only at the handshake edge. Changing in_text/in_key afterwards does not affect the result.
- Datapath: sub_bytes (16 S-box instances), shift_rows and mix_columns are combinational and instantiated once. Arithmetic is GF(2^8), XOR-only, no carries.

Decomposition:
- Shared package aes_pkg:
  - state enum IDLE/ROUND/DONE;
  - AES_NR=10, AES_BLOCK_W=128;
  - S-box table function;
  - xtime function;
  - the FIPS-197 test vectors, for bench reuse.
- One natural sub-module, aes_key_step: combinational; inputs key[127:0] and rcon[7:0]; output the next round key. It performs RotWord, SubWord and the Rcon XOR on word 3, then the chained XOR across words 0-3.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_text 3925841d02dc09fbdc118597196a0b32, with out_valid exactly 10 edges after the handshake.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a. Also check that round steps 1..10 and that the internal rcon at round 9 is 8'h1b.
- Back-pressure: hold out_ready=0 for 20 cycles after done -> out_valid and out_text stay stable, and in_ready=0 throughout. Pulsing in_valid with a new block during that time is ignored. Release -> IDLE, then the second block completes correctly.
- Reset at round 5: assert rst -> same cycle out_valid=0, busy=0, in_ready=1, round=0. Rerun App. B -> correct ciphertext with no residue.
- Input changes after accept: alter in_text/in_key on every cycle after the handshake -> result still 3925841d02dc09fbdc118597196a0b32.
- Back-to-back: in_valid held high with out_ready=1 -> blocks complete every 12 cycles, each ciphertext matches its reference.
